pi1_rrarb: RTL and testbench
============================

// Module: pi1_rrarb
// PURPOSE
// - Single-clock N-master -> 1-slave PI1 arbiter with round-robin fairness, for clusters of PUs sharing one memory port.
// - Generalises the current fixed two-PU shared-port arrangement: any MASTERCOUNT, registered grant, optional bursts.
// - Sits between the per-PU pi1 master ports and the memory/device pi1 slave port.
// PARAMETERS
// - MASTERCOUNT  2   number of master ports; >=2
// - ARCHBITSZ    32  data width; ADDRBITSZ = ARCHBITSZ-clog2(ARCHBITSZ/8)
// - BURSTLEN     4   max consecutive transactions per grant (PI1ARB_BURST_EN only); >=1
// PORTS
// - clk_i       in   1                       clock
// - rst_i       in   1                       reset, synchronous, active-high
// - m_op_i      in   2*MASTERCOUNT           per-master op: 0 NOP, 1 WR, 2 RD, 3 RW(atomic)
// - m_addr_i    in   ADDRBITSZ*MASTERCOUNT   per-master address
// - m_data_i    in   ARCHBITSZ*MASTERCOUNT   per-master write data
// - m_sel_i     in   (ARCHBITSZ/8)*MASTERCOUNT per-master byte select
// - m_data_o    out  ARCHBITSZ               read data, broadcast to all masters (= s_data_i)
// - m_rdy_o     out  MASTERCOUNT             per-master completion strobe
// - s_op_o      out  2                       slave op
// - s_addr_o    out  ADDRBITSZ               slave address
// - s_data_o    out  ARCHBITSZ               slave write data
// - s_sel_o     out  ARCHBITSZ/8             slave byte select
// - s_data_i    in   ARCHBITSZ               slave read data, valid when s_rdy_i && s_op_o!=0
// - s_rdy_i     in   1                       slave completion
// - gnt_o       out  clog2(MASTERCOUNT)      index of current owner (debug/observability)
// BEHAVIOUR
// - Clock: clk_i only; reset: synchronous, active-high rst_i.
// - Master rule: op held stable (op/addr/data/sel) until its m_rdy_o bit pulses; transaction completes in cycle s_op_o!=0 && s_rdy_i.
// - States: IDLE, GNT. Regs: state, gnt (index), rrptr (index), bcnt (clog2(BURSTLEN+1) bits).
// - Reset: state=IDLE, gnt=0, rrptr=0, bcnt=0; hence s_op_o=0, m_rdy_o=0, gnt_o=0 the cycle after rst_i sampled.
// - IDLE: s_op_o=0, s_addr/data/sel=0, m_rdy_o=0. If any m_op_i!=0: gnt <= first requester scanning rrptr, rrptr+1, ... wrapping at MASTERCOUNT-1 -> 0; bcnt<=0; state<=GNT.
// - GNT: s_* driven combinationally from master gnt; m_rdy_o[gnt] = s_rdy_i && m_op_i[gnt]!=0; other bits 0.
// - Latency: request in cycle N -> slave sees op in N+1 (minimum); completion earliest N+1.
// - Completion in GNT: rrptr <= (gnt==MASTERCOUNT-1) ? 0 : gnt+1; release per CONFIGURATION.
// - Master drops op (0) while in GNT with no completion: protocol violation tolerated; state<=IDLE next cycle, rrptr unchanged.
// - Simultaneous requests: only rrptr order matters; a just-served master is last in next scan.
// - rst_i during GNT with s_op_o!=0: transaction abandoned, no m_rdy_o pulse generated after reset; slave must tolerate dropped op.
// - gnt_o = gnt in all states.
// CONFIGURATION
// - Macro PI1ARB_BURST_EN.
// - Undefined: every completion -> state<=IDLE; one IDLE bubble cycle between transactions; strict one-transaction turns.
// - Defined: on completion bcnt<=bcnt+1; if bcnt+1==BURSTLEN -> IDLE, else stay GNT. In GNT with m_op_i[gnt]==0 -> IDLE. Owner may
//   issue back-to-back ops with no bubble up to BURSTLEN; rrptr still updates on every completion.
// TESTING
// - Reset: rst_i=1 2 cycles, all m_op_i=1 -> s_op_o=0, m_rdy_o=0, gnt_o=0 throughout; first grant to master 0 one cycle after release.
// - Single read: M=4, master 2 RD addr 0x40, slave rdy after 3 cycles with data 0xDEADBEEF -> s_addr_o=0x40 from N+1, m_rdy_o=4'b0100 for 1 cycle, m_data_o=0xDEADBEEF.
// - Fairness: M=4, all masters request continuously, s_rdy_i=1 -> grant order 0,1,2,3,0,... ; no master starved >3 turns.
// - Wrap: rrptr=3, masters 0 and 3 request -> 3 served first, then 0; rrptr after 3 =0.
// - Drop: master 1 granted, s_rdy_i=0, m_op_i[1]->0 -> IDLE next cycle, no m_rdy_o pulse, rrptr unchanged.
// - Burst (PI1ARB_BURST_EN, BURSTLEN=4): master 0 six WR, master 1 one WR, s_rdy_i=1 -> 4 back-to-back from 0, then 1, then remaining 2 from 0; without macro -> 0,1,0,0,0,0,0 with bubbles.

Source files
------------

// File: rtl/pi1_rrarb.sv
// Round-robin N-master to 1-slave PI1 arbiter with a registered grant.
// Define PI1ARB_BURST_EN to let the owner issue up to BURSTLEN back-to-back transactions.
module pi1_rrarb #(
  parameter int unsigned MASTERCOUNT = 2,
  parameter int unsigned ARCHBITSZ   = 32,
  parameter int unsigned BURSTLEN    = 4,
  localparam int unsigned SelW  = ARCHBITSZ / 8,
  localparam int unsigned AddrW = ARCHBITSZ - $clog2(SelW),
  localparam int unsigned GntW  = $clog2(MASTERCOUNT),
  localparam int unsigned BcntW = $clog2(BURSTLEN + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [2*MASTERCOUNT-1:0]     m_op_i,
  input  logic [AddrW*MASTERCOUNT-1:0] m_addr_i,
  input  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i,
  input  logic [SelW*MASTERCOUNT-1:0]  m_sel_i,
  output logic [ARCHBITSZ-1:0]         m_data_o,
  output logic [MASTERCOUNT-1:0]       m_rdy_o,
  output logic [1:0]                   s_op_o,
  output logic [AddrW-1:0]             s_addr_o,
  output logic [ARCHBITSZ-1:0]         s_data_o,
  output logic [SelW-1:0]              s_sel_o,
  input  logic [ARCHBITSZ-1:0]         s_data_i,
  input  logic                         s_rdy_i,
  output logic [GntW-1:0]              gnt_o
);

  typedef enum logic [0:0] {StIdle, StGnt} state_e;

  state_e          state_q, state_d;
  logic [GntW-1:0] gnt_q, gnt_d;
  logic [GntW-1:0] rrptr_q, rrptr_d;
  logic [BcntW-1:0] bcnt_q, bcnt_d;

  logic [1:0]           cur_op;
  logic [AddrW-1:0]     cur_addr;
  logic [ARCHBITSZ-1:0] cur_data;
  logic [SelW-1:0]      cur_sel;
  logic                 any_req;
  logic                 done;
  logic [GntW-1:0]      gnt_next;
  logic [BcntW-1:0]     bcnt_inc;

  // First requester found scanning ptr, ptr+1, ... with wrap to 0.
  function automatic logic [GntW-1:0] rr_pick(input logic [2*MASTERCOUNT-1:0] ops,
                                              input logic [GntW-1:0] ptr);
    logic            found;
    logic [GntW-1:0] pick;
    int unsigned     c;
    found = 1'b0;
    pick  = ptr;
    for (int unsigned k = 0; k < MASTERCOUNT; k++) begin
      c = (32'(ptr) + k) % MASTERCOUNT;
      if (!found && (ops[2*c +: 2] != 2'b00)) begin
        found = 1'b1;
        pick  = c[GntW-1:0];
      end
    end
    return pick;
  endfunction

  assign cur_op   = m_op_i[2*gnt_q +: 2];
  assign cur_addr = m_addr_i[AddrW*gnt_q +: AddrW];
  assign cur_data = m_data_i[ARCHBITSZ*gnt_q +: ARCHBITSZ];
  assign cur_sel  = m_sel_i[SelW*gnt_q +: SelW];

  assign any_req  = |m_op_i;
  assign done     = (state_q == StGnt) && (cur_op != 2'b00) && s_rdy_i;
  assign gnt_next = (gnt_q == GntW'(MASTERCOUNT - 1)) ? '0 : gnt_q + 1'b1;
  assign bcnt_inc = bcnt_q + 1'b1;

  assign m_data_o = s_data_i;
  assign gnt_o    = gnt_q;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rrptr_d  = rrptr_q;
    bcnt_d   = bcnt_q;
    s_op_o   = 2'b00;
    s_addr_o = '0;
    s_data_o = '0;
    s_sel_o  = '0;
    m_rdy_o  = '0;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          gnt_d   = rr_pick(m_op_i, rrptr_q);
          bcnt_d  = '0;
          state_d = StGnt;
        end
      end
      StGnt: begin
        s_op_o   = cur_op;
        s_addr_o = cur_addr;
        s_data_o = cur_data;
        s_sel_o  = cur_sel;
        if (done) begin
          m_rdy_o[gnt_q] = 1'b1;
          rrptr_d        = gnt_next;
          bcnt_d         = bcnt_inc;
`ifdef PI1ARB_BURST_EN
          if (bcnt_inc == BcntW'(BURSTLEN)) begin
            state_d = StIdle;
          end
`else
          state_d = StIdle;
`endif
        end else if (cur_op == 2'b00) begin
          // Owner withdrew its request (or ended its burst): give the port back.
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      rrptr_q <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rrptr_q <= rrptr_d;
      bcnt_q  <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_pi1_rrarb.sv
// Bench for pi1_rrarb (4 masters, 32-bit, BURSTLEN 4): spec-level arbiter model checked every
// cycle, plus directed scenarios with literal expected grant orders.
module tb_pi1_rrarb;
  localparam int M  = 4;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int BL = 4;
  localparam logic [1:0] WR = 2'd1;
  localparam logic [1:0] RD = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic s_rdy;
  logic [DW-1:0] s_data;

  logic [1:0]    mop[M];
  logic [AW-1:0] maddr[M];
  logic [DW-1:0] mdata[M];
  logic [SW-1:0] msel[M];

  logic [2*M-1:0]  m_op;
  logic [AW*M-1:0] m_addr;
  logic [DW*M-1:0] m_data;
  logic [SW*M-1:0] m_sel;

  logic [DW-1:0] m_data_o;
  logic [M-1:0]  m_rdy_o;
  logic [1:0]    s_op_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_data_o;
  logic [SW-1:0] s_sel_o;
  logic [1:0]    gnt_o;

  always_comb begin
    for (int i = 0; i < M; i++) begin
      m_op[2*i +: 2]    = mop[i];
      m_addr[AW*i +: AW] = maddr[i];
      m_data[DW*i +: DW] = mdata[i];
      m_sel[SW*i +: SW]  = msel[i];
    end
  end

  pi1_rrarb #(.MASTERCOUNT(M), .ARCHBITSZ(DW), .BURSTLEN(BL)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .m_op_i   (m_op),
    .m_addr_i (m_addr),
    .m_data_i (m_data),
    .m_sel_i  (m_sel),
    .m_data_o (m_data_o),
    .m_rdy_o  (m_rdy_o),
    .s_op_o   (s_op_o),
    .s_addr_o (s_addr_o),
    .s_data_o (s_data_o),
    .s_sel_o  (s_sel_o),
    .s_data_i (s_data),
    .s_rdy_i  (s_rdy),
    .gnt_o    (gnt_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Master agents: each holds its op until its rdy bit, then issues the next one if any remain.
  int            rem[M];
  int            seq[M];
  logic [1:0]    kind[M];
  logic [AW-1:0] base[M];
  logic [M-1:0]  rdy_seen;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < M; i++) begin
      if (rdy_seen[i] === 1'b1 && rem[i] > 0) begin
        rem[i]--;
        seq[i]++;
      end
      mop[i]   = (rem[i] > 0) ? kind[i] : 2'b00;
      maddr[i] = base[i] + AW'(seq[i]);
      mdata[i] = 32'hA000_0000 | (i << 8) | seq[i];
      msel[i]  = SW'(i + 1);
    end
  end

  // Reference model: owner/busy/pointer at transaction level.
  bit  chk_en = 1'b0;
  bit  busy   = 1'b0;
  int  owner  = 0;
  int  ptr    = 0;
  int  cnt    = 0;
  int  cyc    = 0;
  int  served[$];
  int  stamps[$];
  bit  found;
  int  c;
  logic [1:0]    e_op;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [SW-1:0] e_sel;
  logic [M-1:0]  e_rdy;
  logic [1:0]    e_gnt;

  always @(negedge clk) begin
    cyc++;
    rdy_seen = m_rdy_o;
    if (chk_en) begin
      e_rdy = '0;
      if (busy) begin
        e_op = mop[owner]; e_addr = maddr[owner]; e_data = mdata[owner]; e_sel = msel[owner];
        if (s_rdy && mop[owner] != 2'b00) e_rdy[owner] = 1'b1;
      end else begin
        e_op = '0; e_addr = '0; e_data = '0; e_sel = '0;
      end
      e_gnt = owner[1:0];
      chk("model s_op/addr/sel", {s_op_o, s_addr_o, s_sel_o}, {e_op, e_addr, e_sel});
      chk("model s_data", s_data_o, e_data);
      chk("model m_rdy", m_rdy_o, e_rdy);
      chk("model gnt", gnt_o, e_gnt);
      chk("model m_data", m_data_o, s_data);
      for (int i = 0; i < M; i++) begin
        if (m_rdy_o[i] === 1'b1) begin
          served.push_back(i);
          stamps.push_back(cyc);
        end
      end
    end
    // Advance the model to the state after the coming rising edge.
    if (rst) begin
      busy = 0; owner = 0; ptr = 0; cnt = 0;
    end else if (!busy) begin
      found = 0;
      for (int k = 0; k < M; k++) begin
        c = (ptr + k) % M;
        if (!found && mop[c] != 2'b00) begin
          found = 1; owner = c;
        end
      end
      if (found) begin
        busy = 1; cnt = 0;
      end
    end else if (mop[owner] != 2'b00 && s_rdy) begin
      ptr = (owner + 1) % M;
      cnt++;
`ifdef PI1ARB_BURST_EN
      busy = (cnt < BL);
`else
      busy = 0;
`endif
    end else if (mop[owner] == 2'b00) begin
      busy = 0;
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input int i, input int n, input logic [1:0] k, input logic [AW-1:0] b);
    rem[i] = n; kind[i] = k; base[i] = b; seq[i] = 0;
  endtask

  task automatic wait_quiet();
    int  n;
    bit  q;
    n = 0;
    q = 0;
    while (!q && n < 300) begin
      @(negedge clk);
      n++;
      q = (rem[0] == 0 && rem[1] == 0 && rem[2] == 0 && rem[3] == 0 && s_op_o == 2'b00);
    end
    chk("quiet within budget", q, 1'b1);
  endtask

  task automatic wait_gnt(input int g);
    int n;
    bit ok;
    n = 0;
    ok = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      n++;
      ok = (gnt_o == 2'(g) && s_op_o != 2'b00);
    end
    chk("grant within budget", ok, 1'b1);
  endtask

  task automatic check_order(input string name, input int exp[$]);
    chk({name, " count"}, served.size(), exp.size());
    for (int i = 0; i < exp.size() && i < served.size(); i++) begin
      chk(name, served[i], exp[i]);
    end
  endtask

  int exp_q[$];

  initial begin
    rst = 1'b1; s_rdy = 1'b1; s_data = '0;
    for (int i = 0; i < M; i++) begin
      mop[i] = '0; maddr[i] = '0; mdata[i] = '0; msel[i] = '0;
      req(i, 1, WR, AW'(i * 'h100));
    end
    rdy_seen = '0;

    // Reset held two cycles with every master requesting.
    @(posedge clk); #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset s_op", s_op_o, 2'b00);
    chk("reset m_rdy", m_rdy_o, 4'b0000);
    chk("reset gnt", gnt_o, 2'd0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("reset2 s_op", s_op_o, 2'b00);
    chk("reset2 m_rdy", m_rdy_o, 4'b0000);
    chk("reset2 gnt", gnt_o, 2'd0);
    @(negedge clk);
    chk("first grant gnt", gnt_o, 2'd0);
    chk("first grant s_op", s_op_o, WR);
    chk("first grant m_rdy", m_rdy_o, 4'b0001);
    wait_quiet();
    exp_q = '{0, 1, 2, 3};
    check_order("post-reset order", exp_q);

    // Single read from master 2, slave answers a few cycles later.
    served.delete();
    sync(); s_rdy = 1'b0; req(2, 1, RD, 30'h40);
    sync();
    @(negedge clk);
    chk("read cycle N s_op", s_op_o, 2'b00);
    @(negedge clk);
    chk("read N+1 s_op", s_op_o, RD);
    chk("read N+1 s_addr", s_addr_o, 30'h40);
    chk("read N+1 gnt", gnt_o, 2'd2);
    chk("read wait m_rdy", m_rdy_o, 4'b0000);
    sync(); sync(); s_rdy = 1'b1; s_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("read m_rdy", m_rdy_o, 4'b0100);
    chk("read m_data", m_data_o, 32'hDEAD_BEEF);
    chk("read s_addr", s_addr_o, 30'h40);
    sync(); s_data = 32'h1234_5678;
    @(negedge clk);
    chk("read rdy single pulse", m_rdy_o, 4'b0000);
    wait_quiet();
    exp_q = '{2};
    check_order("read order", exp_q);

    // Pointer sits at 3: masters 0 and 3 together -> 3 then 0.
    served.delete();
    sync(); req(0, 1, WR, 30'h200); req(3, 1, WR, 30'h300);
    wait_quiet();
    exp_q = '{3, 0};
    check_order("wrap order", exp_q);

    // Master 1 granted, slave stalls, master withdraws.
    served.delete();
    sync(); s_rdy = 1'b0; req(1, 1, RD, 30'h500);
    wait_gnt(1);
    sync(); rem[1] = 0;
    @(negedge clk);
    @(negedge clk);
    chk("drop m_rdy", m_rdy_o, 4'b0000);
    chk("drop s_op", s_op_o, 2'b00);
    @(negedge clk);
    chk("drop idle s_op", s_op_o, 2'b00);
    chk("drop idle gnt", gnt_o, 2'd1);
    sync(); s_rdy = 1'b1; req(0, 1, WR, 30'h580); req(1, 1, WR, 30'h590);
    wait_quiet();
    exp_q = '{1, 0};
    check_order("after drop order", exp_q);

    // Fairness: move pointer to 0, then all four masters request three times.
    served.delete();
    sync(); req(3, 1, WR, 30'h600);
    wait_quiet();
    served.delete();
    sync();
    for (int i = 0; i < M; i++) req(i, 3, WR, AW'(i * 'h100 + 'h1000));
    wait_quiet();
`ifdef PI1ARB_BURST_EN
    exp_q = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
`else
    exp_q = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
`endif
    check_order("fairness order", exp_q);

    // Burst: master 0 six writes, master 1 one write.
    served.delete(); stamps.delete();
    sync(); req(0, 6, WR, 30'h700); req(1, 1, WR, 30'h800);
    wait_quiet();
`ifdef PI1ARB_BURST_EN
    exp_q = '{0, 0, 0, 0, 1, 0, 0};
    check_order("burst order", exp_q);
    for (int k = 1; k < 4 && k < stamps.size(); k++) chk("burst back-to-back", stamps[k] - stamps[k-1], 1);
`else
    exp_q = '{0, 1, 0, 0, 0, 0, 0};
    check_order("burst order", exp_q);
    for (int k = 1; k < stamps.size(); k++) chk("idle bubble", (stamps[k] - stamps[k-1]) >= 2, 1'b1);
`endif

    // Reset while a stalled transaction is on the slave port.
    served.delete();
    sync(); s_rdy = 1'b0; req(2, 1, RD, 30'h900);
    wait_gnt(2);
    sync(); rst = 1'b1;
    sync(); rst = 1'b0; s_rdy = 1'b1;
    @(negedge clk);
    chk("mid reset s_op", s_op_o, 2'b00);
    chk("mid reset m_rdy", m_rdy_o, 4'b0000);
    chk("mid reset gnt", gnt_o, 2'd0);
    wait_quiet();
    exp_q = '{2};
    check_order("after reset order", exp_q);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
